// File: rtl/alu_seq_if.sv
// Operand/result bundle for alu_seq.
// Two valid/ready handshakes share the same rule: a transfer happens on a
// rising edge where the sender's valid and the receiver's ready are both high;
// valid does not wait for ready.
// The handshakes are i_valid/o_ready (operation in) and o_valid/i_ready (result out).
// dbg_state mirrors the controller state for checkers.
interface alu_seq_if #(
    parameter int DATA_WIDTH = 8,
    parameter int MODE_WIDTH = 6
);
    logic                  i_valid;
    logic                  o_ready;
    logic [DATA_WIDTH-1:0] i_A;
    logic [DATA_WIDTH-1:0] i_B;
    logic [MODE_WIDTH-1:0] i_mode;
    logic                  o_valid;
    logic                  i_ready;
    logic [DATA_WIDTH-1:0] o_result;
    logic [3:0]            o_flags;
    logic [1:0]            dbg_state;

    modport master (
        output i_valid, i_A, i_B, i_mode, i_ready,
        input  o_ready, o_valid, o_result, o_flags, dbg_state
    );

    modport slave (
        input  i_valid, i_A, i_B, i_mode, i_ready,
        output o_ready, o_valid, o_result, o_flags, dbg_state
    );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU: handshake-accepted operation, registered result, and
// shifts performed one bit per cycle instead of with a barrel shifter.
// Optional feature macro: ALU_FLAGS_EN builds the {N,Z,C,V} flag register;
// without it o_flags is constant zero.
module alu_seq #(
    parameter int DATA_WIDTH = 8,
    parameter int MODE_WIDTH = 6,
    parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
    input  logic      i_clk,
    input  logic      i_rst,
    alu_seq_if.slave  bus
);
    localparam int MSB = DATA_WIDTH - 1;

    localparam logic [MODE_WIDTH-1:0] OP_ADD = MODE_WIDTH'(6'b100000);
    localparam logic [MODE_WIDTH-1:0] OP_SUB = MODE_WIDTH'(6'b100010);
    localparam logic [MODE_WIDTH-1:0] OP_AND = MODE_WIDTH'(6'b100100);
    localparam logic [MODE_WIDTH-1:0] OP_OR  = MODE_WIDTH'(6'b100101);
    localparam logic [MODE_WIDTH-1:0] OP_XOR = MODE_WIDTH'(6'b100110);
    localparam logic [MODE_WIDTH-1:0] OP_NOR = MODE_WIDTH'(6'b100111);
    localparam logic [MODE_WIDTH-1:0] OP_SRA = MODE_WIDTH'(6'b000011);
    localparam logic [MODE_WIDTH-1:0] OP_SRL = MODE_WIDTH'(6'b000010);
    localparam logic [MODE_WIDTH-1:0] OP_SLL = MODE_WIDTH'(6'b000000);

`ifdef ALU_FLAGS_EN
    // One extra bit carries the ADD carry-out / SUB borrow.
    localparam int EXT_W = DATA_WIDTH + 1;
`else
    localparam int EXT_W = DATA_WIDTH;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] work_q, shift_next;
    logic [SHAMT_W-1:0]    cnt_q;
    logic [MODE_WIDTH-1:0] op_q;
    logic [DATA_WIDTH-1:0] result_q, acc_res;
    logic [EXT_W-1:0]      sum, diff;
    logic [SHAMT_W-1:0]    shamt;
    logic                  accept, is_shift, go_shift, last_shift;

    assign shamt      = bus.i_B[SHAMT_W-1:0];
    assign accept     = bus.i_valid && (state_q == S_IDLE);
    assign is_shift   = (bus.i_mode == OP_SLL) || (bus.i_mode == OP_SRL) || (bus.i_mode == OP_SRA);
    assign go_shift   = is_shift && (shamt != '0);
    assign last_shift = (cnt_q == SHAMT_W'(1));
    assign sum        = EXT_W'(bus.i_A) + EXT_W'(bus.i_B);
    assign diff       = EXT_W'(bus.i_A) - EXT_W'(bus.i_B);

    assign bus.o_ready   = (state_q == S_IDLE);
    assign bus.o_valid   = (state_q == S_DONE);
    assign bus.o_result  = result_q;
    assign bus.dbg_state = state_q;

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = go_shift ? S_SHIFT : S_DONE;
            S_SHIFT: if (last_shift) state_d = S_DONE;
            S_DONE:  if (bus.i_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Single-cycle result for the operation presented at accept; shifts
    // with a zero amount pass A through.
    always_comb begin
        acc_res = '0;
        case (bus.i_mode)
            OP_ADD:                 acc_res = sum[MSB:0];
            OP_SUB:                 acc_res = diff[MSB:0];
            OP_AND:                 acc_res = bus.i_A & bus.i_B;
            OP_OR:                  acc_res = bus.i_A | bus.i_B;
            OP_XOR:                 acc_res = bus.i_A ^ bus.i_B;
            OP_NOR:                 acc_res = ~(bus.i_A | bus.i_B);
            OP_SRA, OP_SRL, OP_SLL: acc_res = bus.i_A;
            default:                acc_res = '0;
        endcase
    end

    // One-bit step of the iterative shifter.
    always_comb begin
        shift_next = {1'b0, work_q[MSB:1]};
        if (op_q == OP_SLL)      shift_next = {work_q[MSB-1:0], 1'b0};
        else if (op_q == OP_SRA) shift_next = {work_q[MSB], work_q[MSB:1]};
    end

`ifdef ALU_FLAGS_EN
    logic [3:0] flags_q, acc_flags;
    logic       shift_out;

    assign bus.o_flags = flags_q;

    // Bit leaving the work register on this shift step.
    always_comb begin
        shift_out = (op_q == OP_SLL) ? work_q[MSB] : work_q[0];
    end

    // Flags for the single-cycle path; unknown opcodes report all zeros.
    always_comb begin
        acc_flags = 4'b0000;
        case (bus.i_mode)
            OP_ADD: acc_flags = {acc_res[MSB], acc_res == '0, sum[DATA_WIDTH],
                                 (bus.i_A[MSB] == bus.i_B[MSB]) && (acc_res[MSB] != bus.i_A[MSB])};
            OP_SUB: acc_flags = {acc_res[MSB], acc_res == '0, diff[DATA_WIDTH],
                                 (bus.i_A[MSB] != bus.i_B[MSB]) && (acc_res[MSB] != bus.i_A[MSB])};
            OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SRA, OP_SRL, OP_SLL:
                    acc_flags = {acc_res[MSB], acc_res == '0, 2'b00};
            default: acc_flags = 4'b0000;
        endcase
    end
`else
    assign bus.o_flags = 4'b0000;
`endif

    // Operand capture, shift iteration and result/flag registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            result_q <= '0;
            work_q   <= '0;
            cnt_q    <= '0;
            op_q     <= '0;
`ifdef ALU_FLAGS_EN
            flags_q  <= 4'b0000;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        op_q   <= bus.i_mode;
                        work_q <= bus.i_A;
                        cnt_q  <= shamt;
                        if (!go_shift) begin
                            result_q <= acc_res;
`ifdef ALU_FLAGS_EN
                            flags_q  <= acc_flags;
`endif
                        end
                    end
                end
                S_SHIFT: begin
                    work_q <= shift_next;
                    cnt_q  <= cnt_q - SHAMT_W'(1);
                    if (last_shift) begin
                        result_q <= shift_next;
`ifdef ALU_FLAGS_EN
                        flags_q  <= {shift_next[MSB], shift_next == '0, shift_out, 1'b0};
`endif
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
